bcd_entry_to_binary: RTL



---
 rtl/bcd_entry_pkg.sv | 16 +
 rtl/bcd_nibble_adjust.sv | 17 +
 rtl/bcd_entry_to_binary.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/bcd_entry_pkg.sv
// Shared types and constants for the decimal-entry front end.
// Holds the FSM state encoding and the reverse double-dabble constants.
package bcd_entry_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int         CONV_BITS  = 10;
    localparam logic [3:0] DIGIT_MAX  = 4'd9;
    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_SUB    = 4'd3;

endpackage

// File: rtl/bcd_nibble_adjust.sv
// Per-digit corrector for reverse double-dabble: after the right shift,
// any nibble that reached 8 or more has 3 removed.
module bcd_nibble_adjust
    import bcd_entry_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    always_comb begin
        adjusted = digit;
        if (digit >= ADJ_THRESH) begin
            adjusted = digit - ADJ_SUB;
        end
    end

endmodule

// File: rtl/bcd_entry_to_binary.sv
// Buffers up to DIGITS keyed-in BCD digits and converts them to binary with a
// sequential reverse double-dabble. Define BCD_ENTRY_SATURATE_EN to clamp overflowed results.
module bcd_entry_to_binary
    import bcd_entry_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int WIDTH  = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [3:0]            DigitIn,
    input  logic                  DigitStb,
    input  logic                  Start,
    input  logic                  Clear,
    output logic [4*DIGITS-1:0]   Digits,
    output logic [1:0]            DigitCount,
    output logic                  Busy,
    output logic                  Valid,
    output logic [WIDTH-1:0]      Value,
    output logic                  Overflow
);

    localparam int          BCD_W      = 4 * DIGITS;
    localparam int          WORK_W     = BCD_W + CONV_BITS;
    localparam int          ITER_W     = $clog2(CONV_BITS);
    localparam logic [1:0]  COUNT_FULL = 2'(DIGITS);
    localparam logic [31:0] VALUE_MAX  = 32'((64'd1 << WIDTH) - 64'd1);

    state_t              state_reg, state_next;
    logic [ITER_W-1:0]   iter_reg, iter_next;
    logic [WORK_W-1:0]   work_reg, work_next;
    logic [BCD_W-1:0]    digits_reg, digits_next;
    logic [1:0]          count_reg, count_next;
    logic                valid_reg, valid_next;
    logic [WIDTH-1:0]    value_reg, value_next;
    logic                overflow_reg, overflow_next;

    logic [WORK_W-1:0]            shifted;
    logic [DIGITS-1:0][3:0]       adj_nibbles;
    logic [WORK_W-1:0]            step_work;
    logic [CONV_BITS-1:0]         bin;
    logic                         result_ovf;
    logic [WIDTH-1:0]             result_value;

    // One iteration: shift the whole work register right, then correct each BCD nibble.
    assign shifted = work_reg >> 1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adjust
            bcd_nibble_adjust u_adjust (
                .digit    (shifted[CONV_BITS + 4*gi +: 4]),
                .adjusted (adj_nibbles[gi])
            );
        end
    endgenerate

    assign step_work  = {adj_nibbles, shifted[CONV_BITS-1:0]};
    assign bin        = work_reg[CONV_BITS-1:0];
    assign result_ovf = 32'(bin) > VALUE_MAX;

`ifdef BCD_ENTRY_SATURATE_EN
    assign result_value = result_ovf ? {WIDTH{1'b1}} : WIDTH'(bin);
`else
    assign result_value = WIDTH'(bin);
`endif

    always_comb begin
        state_next    = state_reg;
        iter_next     = iter_reg;
        work_next     = work_reg;
        digits_next   = digits_reg;
        count_next    = count_reg;
        valid_next    = 1'b0;
        value_next    = value_reg;
        overflow_next = overflow_reg;

        unique case (state_reg)
            IDLE: begin
                if (Clear) begin
                    digits_next = '0;
                    count_next  = '0;
                end else if (Start) begin
                    // A Start, accepted or not, masks any DigitStb in the same cycle.
                    if (count_reg != 2'd0) begin
                        state_next = CONVERT;
                        iter_next  = '0;
                        work_next  = {digits_reg, {CONV_BITS{1'b0}}};
                    end
                end else if (DigitStb && (DigitIn <= DIGIT_MAX) && (count_reg < COUNT_FULL)) begin
                    digits_next = {digits_reg[BCD_W-5:0], DigitIn};
                    count_next  = count_reg + 2'd1;
                end
            end
            CONVERT: begin
                if (Clear) begin
                    state_next  = IDLE;
                    iter_next   = '0;
                    digits_next = '0;
                    count_next  = '0;
                end else begin
                    work_next = step_work;
                    if (iter_reg == ITER_W'(CONV_BITS - 1)) begin
                        state_next = DONE;
                        iter_next  = '0;
                    end else begin
                        iter_next = iter_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                state_next  = IDLE;
                digits_next = '0;
                count_next  = '0;
                if (!Clear) begin
                    valid_next    = 1'b1;
                    value_next    = result_value;
                    overflow_next = result_ovf;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg    <= IDLE;
            iter_reg     <= '0;
            work_reg     <= '0;
            digits_reg   <= '0;
            count_reg    <= '0;
            valid_reg    <= 1'b0;
            value_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            iter_reg     <= iter_next;
            work_reg     <= work_next;
            digits_reg   <= digits_next;
            count_reg    <= count_next;
            valid_reg    <= valid_next;
            value_reg    <= value_next;
            overflow_reg <= overflow_next;
        end
    end

    assign Digits     = digits_reg;
    assign DigitCount = count_reg;
    assign Busy       = (state_reg != IDLE);
    assign Valid      = valid_reg;
    assign Value      = value_reg;
    assign Overflow   = overflow_reg;

endmodule
